// File: rtl/dff_stuck_monitor_pkg.sv
// ---------------------------------------------------------------------------
// dff_mon_pkg
// Shared types and helpers for the D flip-flop stuck-at monitor.
//   mon_state_e : monitor sequencing state (PRIME / CHECK / FAULT)
//   CW          : per-bit evidence counter width for the default threshold
//   ctr_width() : counter width able to hold the value THRESH
// ---------------------------------------------------------------------------
package dff_mon_pkg;

    typedef enum logic [1:0] {
        PRIME = 2'd0,   // expectation register not yet valid
        CHECK = 2'd1,   // comparing every enabled cycle
        FAULT = 2'd2    // at least one stuck flag raised, still comparing
    } mon_state_e;

    localparam int THRESH_DEFAULT = 4;
    localparam int CW             = $clog2(THRESH_DEFAULT + 1);

    // Width of a counter that must reach (and saturate at) thresh.
    // A threshold below 1 is treated as 1 so the counter is never zero-width.
    function automatic int ctr_width(input int thresh);
        int t;
        t = (thresh < 1) ? 1 : thresh;
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/dff_stuck_monitor_if.sv
// ---------------------------------------------------------------------------
// dff_stuck_monitor_if
// Observation/status bundle between a registered DUT and its stuck-at monitor.
//   en, dut_rst, clr : monitor controls
//   d, q             : DUT data input / data output being observed
//   mismatch         : pulse, previous compare saw q != expected
//   stuck0, stuck1   : sticky per-bit stuck-at flags
//   fault            : any stuck flag raised
//   err_count        : saturating mismatch-cycle count
// master modport drives the controls and DUT data; slave is the monitor.
// ---------------------------------------------------------------------------
interface dff_stuck_monitor_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic             en;
    logic             dut_rst;
    logic             clr;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             mismatch;
    logic [WIDTH-1:0] stuck0;
    logic [WIDTH-1:0] stuck1;
    logic             fault;
    logic [CNT_W-1:0] err_count;

    modport master (
        output en, dut_rst, clr, d, q,
        input  mismatch, stuck0, stuck1, fault, err_count
    );

    modport slave (
        input  en, dut_rst, clr, d, q,
        output mismatch, stuck0, stuck1, fault, err_count
    );
endinterface

// File: rtl/dff_stuck_monitor_bit_ctr.sv
// ---------------------------------------------------------------------------
// dff_stuck_bit_ctr
// Evidence tracker for one observed bit. Two saturating counters accumulate
// consecutive contradicting samples of each polarity; a sticky flag raises on
// the edge its counter reaches THRESH.
//   clk, rst   : clock, asynchronous active-high reset
//   exp        : expected value of this bit (DUT d one cycle earlier)
//   q          : observed DUT output bit
//   cmp        : a compare happens at this edge
//   clr        : synchronous clear of counters and flags (wins over cmp)
//   stuck0/1   : registered sticky flags
//   stuck0_nxt/stuck1_nxt : flag values being loaded at this edge, so the
//                top can register fault in the same cycle the flag appears
// ---------------------------------------------------------------------------
module dff_stuck_bit_ctr
    import dff_mon_pkg::*;
#(
    parameter int THRESH = 4,
    parameter int CW_P   = ctr_width(THRESH)
) (
    input  logic clk,
    input  logic rst,
    input  logic exp,
    input  logic q,
    input  logic cmp,
    input  logic clr,
    output logic stuck0,
    output logic stuck1,
    output logic stuck0_nxt,
    output logic stuck1_nxt
);
    localparam logic [CW_P-1:0] THR = CW_P'(THRESH);
    localparam logic [CW_P-1:0] ONE = CW_P'(1);

    logic [CW_P-1:0] c0_r;
    logic [CW_P-1:0] c1_r;
    logic [CW_P-1:0] c0_nxt_s;
    logic [CW_P-1:0] c1_nxt_s;
    logic            stuck0_r;
    logic            stuck1_r;
    logic            stuck0_nxt_s;
    logic            stuck1_nxt_s;

    // Counter update: a match resets only the counter of its own polarity.
    always_comb begin
        c0_nxt_s = c0_r;
        c1_nxt_s = c1_r;
        if (clr) begin
            c0_nxt_s = '0;
            c1_nxt_s = '0;
        end else if (cmp) begin
            case ({exp, q})
                2'b10: begin
                    if (c0_r != THR) c0_nxt_s = c0_r + ONE;
                    else             c0_nxt_s = c0_r;
                end
                2'b11: c0_nxt_s = '0;
                2'b01: begin
                    if (c1_r != THR) c1_nxt_s = c1_r + ONE;
                    else             c1_nxt_s = c1_r;
                end
                2'b00: c1_nxt_s = '0;
                default: begin
                    c0_nxt_s = c0_r;
                    c1_nxt_s = c1_r;
                end
            endcase
        end else begin
            c0_nxt_s = c0_r;
            c1_nxt_s = c1_r;
        end
    end

    // Sticky flags: raise when the counter arrives at THRESH, drop only on clr.
    always_comb begin
        stuck0_nxt_s = stuck0_r;
        stuck1_nxt_s = stuck1_r;
        if (clr) begin
            stuck0_nxt_s = 1'b0;
            stuck1_nxt_s = 1'b0;
        end else begin
            stuck0_nxt_s = stuck0_r | (c0_nxt_s == THR);
            stuck1_nxt_s = stuck1_r | (c1_nxt_s == THR);
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c0_r     <= '0;
            c1_r     <= '0;
            stuck0_r <= 1'b0;
            stuck1_r <= 1'b0;
        end else begin
            c0_r     <= c0_nxt_s;
            c1_r     <= c1_nxt_s;
            stuck0_r <= stuck0_nxt_s;
            stuck1_r <= stuck1_nxt_s;
        end
    end

    assign stuck0     = stuck0_r;
    assign stuck1     = stuck1_r;
    assign stuck0_nxt = stuck0_nxt_s;
    assign stuck1_nxt = stuck1_nxt_s;

endmodule

// File: rtl/dff_stuck_monitor.sv
// ---------------------------------------------------------------------------
// dff_stuck_monitor
// Passive checker placed at the output of a registered DUT. Captures d into an
// expectation register each enabled cycle and checks that q equals it one
// cycle later. Flags per-bit stuck-at-0/1 after THRESH consecutive
// contradicting samples and counts mismatching compare cycles.
//   clk  : DUT clock
//   rst  : asynchronous active-high reset, clears all state and outputs
//   mon  : dff_stuck_monitor_if.slave
//          inputs  en, dut_rst, clr, d[WIDTH], q[WIDTH]
//          outputs mismatch, stuck0[WIDTH], stuck1[WIDTH], fault,
//                  err_count[CNT_W]
// ---------------------------------------------------------------------------
module dff_stuck_monitor
    import dff_mon_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int THRESH = THRESH_DEFAULT,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dff_stuck_monitor_if.slave   mon
);
    localparam int              CTR_W   = ctr_width(THRESH);
    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ERR_ONE = CNT_W'(1);

    mon_state_e       state_r;
    mon_state_e       state_nxt_s;
    logic [WIDTH-1:0] exp_r;
    logic             active_s;
    logic             cmp_s;
    logic             miss_s;
    logic             any_flag_nxt_s;
    logic [WIDTH-1:0] stuck0_s;
    logic [WIDTH-1:0] stuck1_s;
    logic [WIDTH-1:0] stuck0_nxt_s;
    logic [WIDTH-1:0] stuck1_nxt_s;
    logic             mismatch_r;
    logic             fault_r;
    logic [CNT_W-1:0] err_count_r;

    // Compare qualification: only with a valid expectation, and clr discards it.
    always_comb begin
        active_s = mon.en & ~mon.dut_rst;
        cmp_s    = 1'b0;
        if (active_s && !mon.clr && (state_r != PRIME)) cmp_s = 1'b1;
        else                                            cmp_s = 1'b0;
        miss_s         = cmp_s && (mon.q != exp_r);
        any_flag_nxt_s = (|stuck0_nxt_s) | (|stuck1_nxt_s);
    end

    // Next-state logic; any pause or clear forces a re-prime.
    always_comb begin
        state_nxt_s = state_r;
        if (mon.clr || !active_s) begin
            state_nxt_s = PRIME;
        end else begin
            case (state_r)
                PRIME: state_nxt_s = CHECK;
                CHECK: begin
                    if (any_flag_nxt_s) state_nxt_s = FAULT;
                    else                state_nxt_s = CHECK;
                end
                FAULT: state_nxt_s = FAULT;
                default: state_nxt_s = PRIME;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= PRIME;
        else     state_r <= state_nxt_s;
    end

    // Expectation register: follows d on every enabled cycle, held while paused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           exp_r <= '0;
        else if (active_s) exp_r <= mon.d;
    end

    // Status outputs; a clr cycle never compares, so mismatch drops with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_r  <= 1'b0;
            fault_r     <= 1'b0;
            err_count_r <= '0;
        end else begin
            mismatch_r <= miss_s;
            fault_r    <= any_flag_nxt_s;
            if (mon.clr)                              err_count_r <= '0;
            else if (miss_s && (err_count_r != ERR_MAX)) err_count_r <= err_count_r + ERR_ONE;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_stuck_bit_ctr #(
            .THRESH (THRESH),
            .CW_P   (CTR_W)
        ) u_ctr (
            .clk        (clk),
            .rst        (rst),
            .exp        (exp_r[i]),
            .q          (mon.q[i]),
            .cmp        (cmp_s),
            .clr        (mon.clr),
            .stuck0     (stuck0_s[i]),
            .stuck1     (stuck1_s[i]),
            .stuck0_nxt (stuck0_nxt_s[i]),
            .stuck1_nxt (stuck1_nxt_s[i])
        );
    end

    assign mon.mismatch  = mismatch_r;
    assign mon.stuck0    = stuck0_s;
    assign mon.stuck1    = stuck1_s;
    assign mon.fault     = fault_r;
    assign mon.err_count = err_count_r;

endmodule
